// File: rtl/axi4_stream_mux_master.sv
// NPU AXI4-Stream source: packet-level round-robin merge of NUM_CH
// producer channels into one master port through an output FIFO.
module axi4_stream_mux_master #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_CH     = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   tx_data,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] tx_keep,
  input  logic [NUM_CH-1:0]              tx_last,
  input  logic [NUM_CH-1:0]              tx_valid,
  output logic [NUM_CH-1:0]              tx_ready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]        m_axis_tstrb,
  output logic [DATA_WIDTH/8-1:0]        m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [$clog2(DEPTH):0]         fifo_level,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           pkt_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] rr_q, rr_d;
  logic [CW-1:0] pick, sel, idx;
  logic          found, sel_vld;
  logic          full, push, pop;
  int            t;

  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
  logic [KW-1:0]         ch_keep [NUM_CH];

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [KW-1:0]         mem_keep [DEPTH];
  logic                  mem_last [DEPTH];
  logic [ID_WIDTH-1:0]   mem_id   [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data[i] = tx_data[i*DATA_WIDTH +: DATA_WIDTH];
      ch_keep[i] = tx_keep[i*KW +: KW];
    end
  end

  // Descending scan so the channel nearest rr_q wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    t     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      t = int'(rr_q) + k;
      if (t >= NUM_CH) t = t - NUM_CH;
      idx = CW'(t);
      if (tx_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign full = (level == LW'(DEPTH));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    sel      = grant_q;
    sel_vld  = 1'b0;
    tx_ready = '0;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel     = pick;
        sel_vld = enable && found;
      end
      LOCKED: begin
        sel     = grant_q;
        sel_vld = 1'b1;
      end
      default: ;
    endcase
    if (sel_vld && !full) begin
      tx_ready[sel] = 1'b1;
      push = tx_valid[sel];
    end
    if (push) begin
      if (tx_last[sel]) begin
        state_d = IDLE;
        rr_d = (sel == CW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
      end else begin
        state_d = LOCKED;
        grant_d = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign m_axis_tvalid = (level != '0);
  assign pop = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_keep[i] <= '0;
        mem_last[i] <= 1'b0;
        mem_id[i]   <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= ch_data[sel];
        mem_keep[wr_ptr] <= ch_keep[sel];
        mem_last[wr_ptr] <= tx_last[sel];
        mem_id[wr_ptr]   <= ID_WIDTH'(sel);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (mem_last[rd_ptr]) pkt_count <= pkt_count + 1'b1;
      end
      if (push && !pop) level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end

  assign m_axis_tdata = mem_data[rd_ptr];
  assign m_axis_tkeep = mem_keep[rd_ptr];
  assign m_axis_tstrb = mem_keep[rd_ptr];
  assign m_axis_tlast = mem_last[rd_ptr];
  assign m_axis_tid   = mem_id[rd_ptr];
  assign fifo_level   = level;
  assign busy = (state_q == LOCKED) || (level != '0);

endmodule

// File: tb/tb_axi4_stream_mux_master.sv
// Scoreboard bench for axi4_stream_mux_master: expected beats queued in
// arbitration order, popped and compared on each downstream handshake.
module tb_axi4_stream_mux_master;

  localparam int DW = 128;
  localparam int NC = 4;
  localparam int IW = 4;
  localparam int DP = 4;
  localparam int CNTW = 16;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b1;
  logic [NC*DW-1:0]  tx_data = '0;
  logic [NC*KW-1:0]  tx_keep = '0;
  logic [NC-1:0]     tx_last = '0;
  logic [NC-1:0]     tx_valid = '0;
  logic [NC-1:0]     tx_ready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tstrb;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic [IW-1:0]     m_axis_tid;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [$clog2(DP):0] fifo_level;
  logic              busy;
  logic [CNTW-1:0]   pkt_count;

  beat_t src_q [NC][$];
  beat_t sb_q [$];
  int total = 0;
  int bad = 0;
  logic [NC-1:0] acc;
  logic hold_prev = 1'b0;
  beat_t prev_b;

  axi4_stream_mux_master #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .ID_WIDTH(IW),
    .DEPTH(DP), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .tx_data(tx_data), .tx_keep(tx_keep), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .fifo_level(fifo_level),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(int ch, int k, int n, int base,
                               logic [KW-1:0] kl);
    beat_t b;
    b.data = {32'(ch), 64'h0, 32'(base + k)};
    b.keep = (k == n - 1) ? kl : '1;
    b.last = (k == n - 1);
    b.id   = IW'(ch);
    return b;
  endfunction

  task automatic send(int ch, int n, int base, logic [KW-1:0] kl);
    for (int k = 0; k < n; k++) src_q[ch].push_back(mk(ch, k, n, base, kl));
  endtask

  task automatic expect_pkt(int ch, int n, int base, logic [KW-1:0] kl);
    for (int k = 0; k < n; k++) sb_q.push_back(mk(ch, k, n, base, kl));
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(int max);
    int c;
    c = 0;
    while ((sb_q.size() != 0 || src_q[0].size() != 0 ||
            src_q[1].size() != 0 || src_q[2].size() != 0 ||
            src_q[3].size() != 0 || m_axis_tvalid) && c < max) begin
      step(1);
      c++;
    end
    chk("drain_timeout", 128'(c >= max), 128'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  // Producer model: sample handshakes mid-cycle, retire after the edge.
  always begin
    @(negedge clk);
    acc = rst_n ? (tx_valid & tx_ready) : '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    #2;
    for (int i = 0; i < NC; i++) begin
      if (src_q[i].size() > 0) begin
        tx_valid[i] = 1'b1;
        tx_data[i*DW +: DW] = src_q[i][0].data;
        tx_keep[i*KW +: KW] = src_q[i][0].keep;
        tx_last[i] = src_q[i][0].last;
      end else begin
        tx_valid[i] = 1'b0;
        tx_last[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && hold_prev) begin
      chk("hold_data", m_axis_tdata, prev_b.data);
      chk("hold_ctl", 128'({m_axis_tkeep, m_axis_tlast, m_axis_tid}),
          128'({prev_b.keep, prev_b.last, prev_b.id}));
    end
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (sb_q.size() == 0) begin
        chk("extra_beat", 128'(1), 128'(0));
      end else begin
        e = sb_q.pop_front();
        chk("tdata", m_axis_tdata, e.data);
        chk("tkeep", 128'(m_axis_tkeep), 128'(e.keep));
        chk("tstrb", 128'(m_axis_tstrb), 128'(e.keep));
        chk("tlast", 128'(m_axis_tlast), 128'(e.last));
        chk("tid", 128'(m_axis_tid), 128'(e.id));
      end
    end
    hold_prev = rst_n && m_axis_tvalid && !m_axis_tready;
    prev_b = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid};
  end

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_level", 128'(fifo_level), 128'(0));
    chk("rst_pkt", 128'(pkt_count), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(tx_ready), 128'(0));
    chk("rst_tdata", m_axis_tdata, 128'(0));
    rst_n = 1'b1;

    // single 3-beat packet on ch0, one-cycle latency
    send(0, 3, 'hA0, '1);
    expect_pkt(0, 3, 'hA0, '1);
    @(negedge clk); #1;
    chk("t1_ready", 128'(tx_ready), 128'(4'b0001));
    chk("t1_pre_tvalid", 128'(m_axis_tvalid), 128'(0));
    @(negedge clk); #1;
    chk("t1_lat_tvalid", 128'(m_axis_tvalid), 128'(1));
    wait_drain(30);
    chk("t1_pkt", 128'(pkt_count), 128'(1));

    // round robin across all channels
    do_reset();
    for (int c = 0; c < NC; c++) send(c, 2, 'h100 * (c + 1), 16'h00ff);
    for (int c = 0; c < NC; c++) expect_pkt(c, 2, 'h100 * (c + 1), 16'h00ff);
    wait_drain(60);
    chk("t2_pkt", 128'(pkt_count), 128'(4));
    send(1, 1, 'h1100, '1);
    send(0, 1, 'h1000, '1);
    expect_pkt(0, 1, 'h1000, '1);
    expect_pkt(1, 1, 'h1100, '1);
    wait_drain(30);
    chk("t2_pkt2", 128'(pkt_count), 128'(6));

    // lock holds against a competing channel
    send(2, 4, 'h200, 16'h0003);
    expect_pkt(2, 4, 'h200, 16'h0003);
    step(2);
    send(1, 3, 'h300, 16'h8000);
    expect_pkt(1, 3, 'h300, 16'h8000);
    @(negedge clk); #1;
    chk("t3_lock_a", 128'(tx_ready), 128'(4'b0100));
    @(negedge clk); #1;
    chk("t3_lock_b", 128'(tx_ready), 128'(4'b0100));
    @(negedge clk); #1;
    chk("t3_next", 128'(tx_ready), 128'(4'b0010));
    wait_drain(40);
    chk("t3_pkt", 128'(pkt_count), 128'(8));

    // backpressure fills FIFO, then drains
    m_axis_tready = 1'b0;
    send(3, 6, 'h400, 16'h0f0f);
    expect_pkt(3, 6, 'h400, 16'h0f0f);
    step(6);
    chk("t4_full", 128'(fifo_level), 128'(4));
    chk("t4_ready", 128'(tx_ready), 128'(0));
    chk("t4_head", m_axis_tdata, mk(3, 0, 6, 'h400, 16'h0f0f).data);
    chk("t4_tid", 128'(m_axis_tid), 128'(3));
    m_axis_tready = 1'b1;
    step(1);
    chk("t4_lvl3", 128'(fifo_level), 128'(3));
    for (int k = 0; k < 4; k++) begin
      chk("t4_stream", 128'(m_axis_tvalid), 128'(1));
      step(1);
    end
    wait_drain(40);
    chk("t4_pkt", 128'(pkt_count), 128'(9));

    // enable low only blocks new packets; null beat forwarded
    send(3, 3, 'h500, '0);
    expect_pkt(3, 3, 'h500, '0);
    step(1);
    enable = 1'b0;
    send(0, 2, 'h600, '1);
    expect_pkt(0, 2, 'h600, '1);
    step(4);
    chk("t5_noready", 128'(tx_ready), 128'(0));
    chk("t5_idle", 128'(busy), 128'(0));
    chk("t5_held", 128'(src_q[0].size()), 128'(2));
    enable = 1'b1;
    wait_drain(40);
    chk("t5_pkt", 128'(pkt_count), 128'(11));

    // reset mid-packet with two beats buffered
    m_axis_tready = 1'b0;
    send(1, 4, 'h700, '1);
    step(2);
    chk("t6_level", 128'(fifo_level), 128'(2));
    chk("t6_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    for (int c = 0; c < NC; c++) src_q[c].delete();
    sb_q.delete();
    step(1);
    chk("t6_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("t6_lvl0", 128'(fifo_level), 128'(0));
    chk("t6_pkt0", 128'(pkt_count), 128'(0));
    chk("t6_busy0", 128'(busy), 128'(0));
    chk("t6_ready0", 128'(tx_ready), 128'(0));
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    send(2, 1, 'h800, 16'h0001);
    expect_pkt(2, 1, 'h800, 16'h0001);
    wait_drain(30);
    chk("t6_pkt1", 128'(pkt_count), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_stream_mux_master.md
Name: axi4_stream_mux_master

Overview:
- Next-generation AXI4-Stream source for the NPU data path. It merges NUM_CH independent producer channels onto one AXI4-Stream master port.
- Arbitration is round-robin at packet granularity; a granted channel keeps the bus until its TLAST beat.
- An output FIFO of DEPTH entries absorbs downstream backpressure.
- TID carries the source channel index. TKEEP/TSTRB are per-beat from the producer, not tied high.

Parameters:
- DATA_WIDTH, 128, tdata width in bits; multiple of 8.
- NUM_CH, 4, number of producer channels; 1..16.
- ID_WIDTH, 4, tid width; must be >= max(1, $clog2(NUM_CH)).
- DEPTH, 4, output FIFO entries; power of 2, >= 2.
- CNT_WIDTH, 16, width of the packet counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  1 = arbiter may start new packets.
- tx_data  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- tx_keep  in  NUM_CH*DATA_WIDTH/8  per-channel byte keep.
- tx_last  in  NUM_CH  per-channel end of packet.
- tx_valid  in  NUM_CH  per-channel beat valid.
- tx_ready  out  NUM_CH  per-channel beat accepted.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tstrb  out  DATA_WIDTH/8  equals m_axis_tkeep.
- m_axis_tkeep  out  DATA_WIDTH/8  byte keep.
- m_axis_tlast  out  1  end of packet.
- m_axis_tid  out  ID_WIDTH  source channel index, zero-extended.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- busy  out  1  1 while a packet is locked or the FIFO is non-empty.
- pkt_count  out  CNT_WIDTH  number of TLAST beats delivered downstream.

Behaviour:
- Reset: clk edge with rst_n=0 clears everything.
  - FIFO is emptied; fifo_level=0, m_axis_tvalid=0.
  - Output data regs tdata/tkeep/tlast/tid = 0.
  - lock=0, grant=0, rr_ptr=0, pkt_count=0; busy=0, tx_ready=0.
  - Reset mid-packet drops the partial packet; no recovery beat is emitted.
- Arbiter: two states, IDLE (lock=0) and LOCKED (lock=1, holds grant).
  - IDLE: if enable=1, choose the first i with tx_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - The choice is combinational; the first beat can be accepted in the same cycle.
  - IDLE with enable=0 or no tx_valid: no grant, all tx_ready=0.
  - On an accepted beat with tx_last=0: next state LOCKED on that channel.
  - On an accepted beat with tx_last=1: stay IDLE; rr_ptr <= (i+1) mod NUM_CH.
  - LOCKED: only the granted channel is served. enable is ignored until the packet's last beat.
  - Other channels' tx_valid are ignored, with no starvation of the locked packet.
  - On accepting the granted channel's tx_last beat: go to IDLE; rr_ptr <= (grant+1) mod NUM_CH.
- tx_ready[i] = (i is the selected/locked channel) && fifo_level < DEPTH. No pass-through when full, even if a pop occurs in the same cycle.
- A beat is accepted when tx_valid[i] && tx_ready[i]. It is pushed as {data, keep, last, tid=i}.
- FIFO and output:
  - The output is the registered FIFO head.
  - Latency: a beat accepted into an empty FIFO at edge N gives m_axis_tvalid=1 after edge N.
  - Pop occurs on m_axis_tvalid && m_axis_tready.
  - AXIS rule: once m_axis_tvalid=1, tdata/tkeep/tlast/tid stay stable until the handshake.
  - Simultaneous push and pop: fifo_level is unchanged and order is preserved.
  - Throughput: 1 beat/cycle sustained when m_axis_tready=1 and DEPTH >= 2.
  - Pointers wrap modulo DEPTH.
- pkt_count increments on each downstream handshake with m_axis_tlast=1 and wraps at 2^CNT_WIDTH.
- Beats with tx_keep all zeros are forwarded unchanged; the block does not filter null beats.
- busy = lock || (fifo_level != 0).

Test Plan:
- Reset, then ch0 sends a 3-beat packet (data 0xA0..0xA2, keep all ones), tready=1 -> 3 beats with tid=0, tlast on the 3rd beat only. First tvalid appears 1 cycle after the first accept. pkt_count=1.
- All 4 channels hold 2-beat packets valid simultaneously -> output order is ch0, ch1, ch2, ch3 with no interleaving inside any packet. pkt_count=4; rr_ptr returns to 0.
- ch2 in a 4-beat packet, ch1 asserts valid mid-packet -> ch1 stays at tx_ready=0 until ch2's last beat is accepted; ch1 is granted next.
- tready held at 0 with DEPTH=4 -> after 4 accepts fifo_level=4 and tx_ready=0. tdata/tid stay stable. Releasing tready drains 4 beats in order, one per cycle.
- enable=0 with ch3 mid-packet -> ch3 completes its packet and no new packet starts. enable=1 resumes grants.
- rst_n=0 for one cycle mid-packet with the FIFO holding 2 beats -> next cycle tvalid=0, fifo_level=0, pkt_count=0, busy=0, all tx_ready=0.
